pipeline_hazard_ctrl: RTL

Pipeline hazard sequencer for the 5-stage RISC-V core. It sits beside the EX-stage forwarding logic and owns every stall and flush control in the pipeline. It resolves load-use hazards in D, taken-branch redirects from E, multi-cycle MUL/DIV occupancy in E (start/done handshake), and data-memory wait states in M. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard sequencer.
// master = the sequencer (reads hazard sources, drives stall/flush controls);
// slave  = the datapath side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard sources
  logic [4:0]       RS1_D;
  logic [4:0]       RS2_D;
  logic [4:0]       RD_E;
  logic             MemReadE;
  logic             PCSrcE;
  logic             MduOpE;
  logic             MduDone;
  logic             MemReqM;
  logic             MemReadyM;
  logic             CntClr;
  // pipeline controls
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             FlushW;
  logic             MduStart;
  logic [CNT_W-1:0] StallCount;

  modport master (
    input  RS1_D, RS2_D, RD_E, MemReadE, PCSrcE, MduOpE, MduDone,
           MemReqM, MemReadyM, CntClr,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           MduStart, StallCount
  );

  modport slave (
    output RS1_D, RS2_D, RD_E, MemReadE, PCSrcE, MduOpE, MduDone,
           MemReqM, MemReadyM, CntClr,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
           MduStart, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use, taken-branch redirect,
// multi-cycle MUL/DIV occupancy and data-memory wait states, plus a
// saturating stall-cycle counter. Controls are combinational from state+inputs.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.master hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic memstall, loaduse, mdu_occ;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic mdu_start;

  // Hazard terms. MDU_DONE means the result is already latched, so the MDU
  // op in E no longer occupies the stage and only memory can hold it.
  always_comb begin
    memstall = hz.MemReqM & ~hz.MemReadyM;
    loaduse  = hz.MemReadE & (hz.RD_E != 5'd0) &
               ((hz.RD_E == hz.RS1_D) | (hz.RD_E == hz.RS2_D));
    mdu_occ  = ((state_q == RUN) & hz.MduOpE) |
               ((state_q == MDU_BUSY) & ~hz.MduDone);
  end

  // Prioritised stall/flush decode: memory wait > MDU > branch > load-use.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;
    mdu_start = (state_q == RUN) & hz.MduOpE & ~memstall;
    if (memstall) begin
      // whole pipe frozen; a branch sitting in E waits until M completes
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (mdu_occ) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (loaduse && state_q != MDU_DONE) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Controls are forced quiet while reset is asserted so nothing pulses the
  // MUL/DIV unit or the pipeline registers during reset.
  assign hz.StallF     = stall_f & ~rst;
  assign hz.StallD     = stall_d & ~rst;
  assign hz.StallE     = stall_e & ~rst;
  assign hz.StallM     = stall_m & ~rst;
  assign hz.FlushD     = flush_d & ~rst;
  assign hz.FlushE     = flush_e & ~rst;
  assign hz.FlushM     = flush_m & ~rst;
  assign hz.FlushW     = flush_w & ~rst;
  assign hz.MduStart   = mdu_start & ~rst;
  assign hz.StallCount = cnt_q;

  // Next-state: MduDone during a memory wait is parked in MDU_DONE so the
  // op is never restarted; MduDone seen in RUN/MDU_DONE is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mdu_start) state_d = MDU_BUSY;
      MDU_BUSY: if (hz.MduDone) state_d = memstall ? MDU_DONE : RUN;
      MDU_DONE: if (!memstall) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Stall-cycle counter: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (hz.CntClr)
      cnt_d = '0;
    else if (stall_f && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
